disp_chan_sel: RTL and testbench
================================

Name: disp_chan_sel

Overview:
Parametrised, synchronous display-channel selector for the taxi-fare meter front panel. It picks one of N_CH measurement channels (distance, time, price, and optionally extras such as waiting time or surcharge) and drives the selected channel's data and decimal-point mask to the 7-segment driver. It supports manual forward/backward stepping by debounced keys and an auto-scroll mode with a programmable dwell time. It sits between the meter datapath and the segment scan driver.

Parameters:
N_CH, 3, number of display channels (2..8).
DATA_W, 16, width of each channel's BCD data word.
PNT_W, 4, width of each channel's decimal-point mask.
DWELL_CYC, 100_000_000, clk cycles each channel is shown in auto mode (>=2).
SEL_W, $clog2(N_CH), selector width (derived; not overridden).

Ports:
clk  in  1  system clock.
sys_reset_n  in  1  reset, asynchronous, active-low.
key_next  in  1  debounced, clk-synchronous level; a rising edge steps forward.
key_prev  in  1  debounced, clk-synchronous level; a rising edge steps backward.
auto_en  in  1  level; 1 = auto-scroll mode.
ch_data  in  N_CH*DATA_W  channel data, flattened; channel k is at [k*DATA_W +: DATA_W].
ch_point  in  N_CH*PNT_W  channel decimal-point masks, flattened the same way.
dis_data  out  DATA_W  registered data of the selected channel.
dis_point  out  PNT_W  registered point mask of the selected channel.
dis_sel  out  SEL_W  current channel index.
dis_chg  out  1  one-cycle pulse when dis_sel changes.

Behaviour:
- Reset (async assert, sync release): sel=0, dwell counter=0, state=MANUAL, edge-detector history regs=1 (so a key held through reset does not step), dis_data=0, dis_point=0, dis_sel=0, dis_chg=0.
- Edge detect: next_p = key_next & ~key_next_d; prev_p likewise. A held key steps exactly once.
- next_p & prev_p in the same cycle: both ignored, no step, dwell not restarted.
- Step forward: sel = (sel==N_CH-1) ? 0 : sel+1. Step backward: sel = (sel==0) ? N_CH-1 : sel-1. Values >= N_CH are never produced.
- FSM has two states:
  - MANUAL: sel changes only on key steps; dwell held at 0. Move to AUTO when auto_en=1.
  - AUTO: dwell increments every cycle. When dwell==DWELL_CYC-1, step forward and set dwell=0. A key step in AUTO takes effect and also sets dwell=0. If a key step and the dwell expiry occur in the same cycle, only the key step is applied (a single step). Move to MANUAL when auto_en=0; sel is kept and dwell is cleared.
- Output latency: dis_sel follows sel one cycle after the triggering edge or expiry. dis_data and dis_point are registered every cycle from ch_data and ch_point indexed by the registered sel. Live input changes on the selected channel therefore appear one cycle later.
- dis_chg is 1 in the cycle after sel changes; otherwise 0. No pulse is generated for ignored simultaneous presses.
- Mid-operation reset clears everything immediately, with no residual dis_chg pulse.
- Width rules: dwell counter is $clog2(DWELL_CYC) bits and never exceeds DWELL_CYC-1. sel is SEL_W bits with explicit wrap compare, not modulo 2^SEL_W.

Decomposition:
- Package disp_pkg holds the FSM state enum (MANUAL, AUTO), default N_CH/DATA_W/PNT_W constants, and channel index constants CH_DIST=0, CH_TIME=1, CH_PRICE=2.
- One sub-module, key_edge_det: a 1-bit rising-edge detector with async active-low reset (history reset to 1). It is instantiated twice.
- The channel read mux is an indexed part-select inside disp_chan_sel; it is not a separate module.

Test Plan (N_CH=3, DWELL_CYC=4 unless stated):
- Reset, then ch_data = {16'h0300, 16'h0120, 16'h0045}, ch_point={4'b0010, 4'b0100, 4'b0010} -> dis_sel=0, dis_data=16'h0045, dis_point=4'b0010, dis_chg=0.
- key_next held high for 10 cycles -> exactly one step: dis_sel=1, dis_data=16'h0120, one dis_chg pulse. Three further presses -> 2, 0, 1 (wrap-around).
- From sel=0, one key_prev press -> dis_sel=2, dis_data=16'h0300. key_next and key_prev rising together -> no change, no dis_chg.
- auto_en=1 from sel=0 -> dis_sel steps 0→1→2→0 every 4 cycles. A key_next pulse on the expiry cycle -> single step, and the next auto step comes 4 cycles later. auto_en=0 -> sel frozen.
- Change ch_data of the selected channel 16'h0045→16'h0046 -> dis_data updates exactly one cycle later. Assert sys_reset_n=0 mid-auto-scroll -> all outputs 0 immediately, state=MANUAL after release.
- N_CH=5, DATA_W=20 build: 5 next presses return to sel=0; dis_sel never exceeds 4; per-channel 20-bit data routed correctly.

Source files
------------

// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared types and constants for the display channel selector
package disp_pkg;

    // Selector operating mode: manual key stepping or timed auto-scroll
    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } disp_state_e;

    // Default geometry of the taxi-meter front panel
    localparam int DEF_N_CH      = 3;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_PNT_W     = 4;
    localparam int DEF_DWELL_CYC = 100_000_000;

    // Fixed channel positions on the panel
    localparam int CH_DIST  = 0;
    localparam int CH_TIME  = 1;
    localparam int CH_PRICE = 2;

endpackage

// File: rtl/key_edge_det.sv
// rtl/key_edge_det.sv - one-bit rising-edge detector for debounced keys
module key_edge_det (
    input  logic clk,
    input  logic sys_reset_n,
    input  logic key_i,
    output logic rise_o
);

    logic hist_q;

    // History resets high so a key already held at reset release is not seen as a press
    always_ff @(posedge clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            hist_q <= 1'b1;
        end else begin
            hist_q <= key_i;
        end
    end

    assign rise_o = key_i & ~hist_q;

endmodule

// File: rtl/disp_chan_sel.sv
// rtl/disp_chan_sel.sv - display channel selector with key stepping and auto-scroll
module disp_chan_sel
    import disp_pkg::*;
#(
    parameter  int N_CH      = DEF_N_CH,
    parameter  int DATA_W    = DEF_DATA_W,
    parameter  int PNT_W     = DEF_PNT_W,
    parameter  int DWELL_CYC = DEF_DWELL_CYC,
    localparam int SEL_W     = $clog2(N_CH)
) (
    input  logic                    clk,
    input  logic                    sys_reset_n,
    input  logic                    key_next,
    input  logic                    key_prev,
    input  logic                    auto_en,
    input  logic [N_CH*DATA_W-1:0]  ch_data,
    input  logic [N_CH*PNT_W-1:0]   ch_point,
    output logic [DATA_W-1:0]       dis_data,
    output logic [PNT_W-1:0]        dis_point,
    output logic [SEL_W-1:0]        dis_sel,
    output logic                    dis_chg
);

    localparam int               DW_W       = $clog2(DWELL_CYC);
    localparam logic [SEL_W-1:0] LAST_CH    = SEL_W'(N_CH - 1);
    localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL_CYC - 1);

    disp_state_e       state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [DW_W-1:0]   dwell_q, dwell_d;
    logic              chg_q, chg_d;
    logic [DATA_W-1:0] dis_data_q;
    logic [PNT_W-1:0]  dis_point_q;

    logic              next_p, prev_p;
    logic              step_fwd, step_bwd;
    logic [SEL_W-1:0]  sel_fwd, sel_bwd;

    key_edge_det u_next_edge (
        .clk         (clk),
        .sys_reset_n (sys_reset_n),
        .key_i       (key_next),
        .rise_o      (next_p)
    );

    key_edge_det u_prev_edge (
        .clk         (clk),
        .sys_reset_n (sys_reset_n),
        .key_i       (key_prev),
        .rise_o      (prev_p)
    );

    // Simultaneous presses cancel each other out
    assign step_fwd = next_p & ~prev_p;
    assign step_bwd = prev_p & ~next_p;

    // Explicit wrap so non-power-of-two channel counts never reach an unused index
    assign sel_fwd = (sel_q == LAST_CH) ? '0 : sel_q + 1'b1;
    assign sel_bwd = (sel_q == '0) ? LAST_CH : sel_q - 1'b1;

    // Mode register
    always_ff @(posedge clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state_q <= MANUAL;
        end else begin
            state_q <= state_d;
        end
    end

    // Mode follows the auto_en level
    always_comb begin
        state_d = state_q;
        case (state_q)
            MANUAL:  if (auto_en)  state_d = AUTO;
            AUTO:    if (!auto_en) state_d = MANUAL;
            default: state_d = MANUAL;
        endcase
    end

    // Selection and dwell update; a key step wins over a coincident dwell expiry
    always_comb begin
        sel_d   = sel_q;
        dwell_d = '0;
        chg_d   = 1'b0;
        if (step_fwd) begin
            sel_d = sel_fwd;
            chg_d = 1'b1;
        end else if (step_bwd) begin
            sel_d = sel_bwd;
            chg_d = 1'b1;
        end else if (state_q == AUTO && auto_en) begin
            if (dwell_q == DWELL_LAST) begin
                sel_d = sel_fwd;
                chg_d = 1'b1;
            end else begin
                dwell_d = dwell_q + 1'b1;
            end
        end
    end

    // Selection, dwell counter and change pulse
    always_ff @(posedge clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            sel_q   <= '0;
            dwell_q <= '0;
            chg_q   <= 1'b0;
        end else begin
            sel_q   <= sel_d;
            dwell_q <= dwell_d;
            chg_q   <= chg_d;
        end
    end

    // Channel read mux, registered every cycle from the registered selection
    always_ff @(posedge clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            dis_data_q  <= '0;
            dis_point_q <= '0;
        end else begin
            dis_data_q  <= ch_data[int'(sel_q)*DATA_W +: DATA_W];
            dis_point_q <= ch_point[int'(sel_q)*PNT_W +: PNT_W];
        end
    end

    assign dis_data  = dis_data_q;
    assign dis_point = dis_point_q;
    assign dis_sel   = sel_q;
    assign dis_chg   = chg_q;

endmodule

// File: tb/tb_disp_chan_sel.sv
// tb/tb_disp_chan_sel.sv - directed self-checking bench for disp_chan_sel
module tb_disp_chan_sel;
    import disp_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        sys_reset_n;
    logic        key_next, key_prev, auto_en;
    logic [47:0] ch_data;
    logic [11:0] ch_point;
    logic [15:0] dis_data;
    logic [3:0]  dis_point;
    logic [1:0]  dis_sel;
    logic        dis_chg;

    logic        key_next5, key_prev5, auto_en5;
    logic [99:0] ch_data5;
    logic [19:0] ch_point5;
    logic [19:0] dis_data5;
    logic [3:0]  dis_point5;
    logic [2:0]  dis_sel5;
    logic        dis_chg5;

    int total = 0;
    int bad   = 0;

    disp_chan_sel #(.N_CH(3), .DATA_W(16), .PNT_W(4), .DWELL_CYC(4)) dut (
        .clk         (clk),
        .sys_reset_n (sys_reset_n),
        .key_next    (key_next),
        .key_prev    (key_prev),
        .auto_en     (auto_en),
        .ch_data     (ch_data),
        .ch_point    (ch_point),
        .dis_data    (dis_data),
        .dis_point   (dis_point),
        .dis_sel     (dis_sel),
        .dis_chg     (dis_chg)
    );

    disp_chan_sel #(.N_CH(5), .DATA_W(20), .PNT_W(4), .DWELL_CYC(4)) dut5 (
        .clk         (clk),
        .sys_reset_n (sys_reset_n),
        .key_next    (key_next5),
        .key_prev    (key_prev5),
        .auto_en     (auto_en5),
        .ch_data     (ch_data5),
        .ch_point    (ch_point5),
        .dis_data    (dis_data5),
        .dis_point   (dis_point5),
        .dis_sel     (dis_sel5),
        .dis_chg     (dis_chg5)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // which: 0 = key_next, 1 = key_prev, 2 = key_next of the 5-channel build
    task automatic press(input int which, output logic chg_seen);
        case (which)
            0: key_next  = 1'b1;
            1: key_prev  = 1'b1;
            default: key_next5 = 1'b1;
        endcase
        tick();
        chg_seen = (which == 2) ? dis_chg5 : dis_chg;
        key_next  = 1'b0;
        key_prev  = 1'b0;
        key_next5 = 1'b0;
        tick();
    endtask

    function automatic logic [19:0] ch5(input int k);
        return 20'((k + 1) * 65536 + k);
    endfunction

    function automatic logic [3:0] pt5(input int k);
        return 4'(1 << (k % 4));
    endfunction

    initial begin
        logic c;
        int   pulses;
        int   max_sel;
        int   exp_wrap [3];
        exp_wrap = '{2, 0, 1};

        sys_reset_n = 1'b0;
        key_next = 1'b0; key_prev = 1'b0; auto_en = 1'b0;
        key_next5 = 1'b0; key_prev5 = 1'b0; auto_en5 = 1'b0;
        ch_data  = {16'h0300, 16'h0120, 16'h0045};
        ch_point = {4'b0010, 4'b0100, 4'b0010};
        ch_data5  = '0;
        ch_point5 = '0;
        for (int k = 0; k < 5; k++) begin
            ch_data5[k*20 +: 20] = ch5(k);
            ch_point5[k*4 +: 4]  = pt5(k);
        end

        repeat (3) tick();
        chk("rst_sel",   dis_sel,   0);
        chk("rst_data",  dis_data,  0);
        chk("rst_point", dis_point, 0);
        chk("rst_chg",   dis_chg,   0);

        sys_reset_n = 1'b1;
        tick(); tick();
        chk("idle_sel",   dis_sel,   CH_DIST);
        chk("idle_data",  dis_data,  16'h0045);
        chk("idle_point", dis_point, 4'b0010);
        chk("idle_chg",   dis_chg,   0);

        key_next = 1'b1;
        tick();
        chk("hold_sel", dis_sel, CH_TIME);
        chk("hold_chg", dis_chg, 1);
        pulses = 0;
        repeat (9) begin
            tick();
            pulses += int'(dis_chg);
        end
        chk("hold_extra_pulses", pulses, 0);
        chk("hold_sel_after", dis_sel, CH_TIME);
        key_next = 1'b0;
        tick();
        chk("hold_data",  dis_data,  16'h0120);
        chk("hold_point", dis_point, 4'b0100);

        for (int i = 0; i < 3; i++) begin
            press(0, c);
            chk("wrap_sel", dis_sel, exp_wrap[i]);
            chk("wrap_chg", c, 1);
        end

        press(1, c);
        chk("prev_to0", dis_sel, 0);
        press(1, c);
        chk("prev_wrap_sel", dis_sel, CH_PRICE);
        chk("prev_wrap_chg", c, 1);
        chk("prev_data",  dis_data,  16'h0300);
        chk("prev_point", dis_point, 4'b0010);

        key_next = 1'b1; key_prev = 1'b1;
        tick();
        chk("sim_sel", dis_sel, 2);
        chk("sim_chg", dis_chg, 0);
        tick();
        chk("sim_sel2", dis_sel, 2);
        chk("sim_chg2", dis_chg, 0);
        key_next = 1'b0; key_prev = 1'b0;
        tick();

        press(0, c);
        chk("auto_start", dis_sel, 0);
        auto_en = 1'b1;
        tick();
        for (int s = 1; s <= 3; s++) begin
            repeat (3) tick();
            chk("auto_hold", dis_sel, (s - 1) % 3);
            tick();
            chk("auto_step", dis_sel, s % 3);
            chk("auto_chg", dis_chg, 1);
        end

        repeat (3) tick();
        key_next = 1'b1;
        tick();
        chk("coll_sel", dis_sel, 1);
        chk("coll_chg", dis_chg, 1);
        key_next = 1'b0;
        repeat (3) tick();
        chk("coll_hold", dis_sel, 1);
        tick();
        chk("coll_next", dis_sel, 2);

        auto_en = 1'b0;
        repeat (8) tick();
        chk("frz_sel", dis_sel, 2);

        press(0, c);
        chk("live_sel", dis_sel, 0);
        chk("live_pre", dis_data, 16'h0045);
        ch_data[15:0] = 16'h0046;
        #1;
        chk("live_same", dis_data, 16'h0045);
        tick();
        chk("live_upd", dis_data, 16'h0046);

        auto_en = 1'b1;
        tick();
        repeat (4) tick();
        chk("mid_pre_sel", dis_sel, 1);
        chk("mid_pre_chg", dis_chg, 1);
        sys_reset_n = 1'b0;
        key_next = 1'b1;
        #1;
        chk("mr_sel",   dis_sel,   0);
        chk("mr_data",  dis_data,  0);
        chk("mr_point", dis_point, 0);
        chk("mr_chg",   dis_chg,   0);
        auto_en = 1'b0;
        tick(); tick();
        sys_reset_n = 1'b1;
        repeat (3) tick();
        chk("held_key_sel", dis_sel, 0);
        chk("held_key_chg", dis_chg, 0);
        key_next = 1'b0;
        repeat (6) tick();
        chk("post_rst_sel", dis_sel, 0);
        auto_en = 1'b1;
        tick();
        repeat (3) tick();
        chk("post_auto_hold", dis_sel, 0);
        tick();
        chk("post_auto_step", dis_sel, 1);
        auto_en = 1'b0;
        tick();

        max_sel = 0;
        for (int i = 0; i < 5; i++) begin
            press(2, c);
            chk("n5_sel",   dis_sel5,   (i + 1) % 5);
            chk("n5_chg",   c, 1);
            chk("n5_data",  dis_data5,  ch5((i + 1) % 5));
            chk("n5_point", dis_point5, pt5((i + 1) % 5));
            if (int'(dis_sel5) > max_sel) max_sel = int'(dis_sel5);
        end
        chk("n5_max_sel", max_sel, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
